// File: rtl/mul_slave_ctrl.sv
// mul_slave_ctrl: bus-slave register front end for the 32x32 signed
// sequential multiplier. Holds the operands, sequences the start/clear
// pulses, captures the 64-bit product and drives a level interrupt.
module mul_slave_ctrl #(
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              s_sel,
  input  logic              s_wr,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [31:0]       s_din,
  output logic [31:0]       s_dout,
  output logic              m_interrupt,
  output logic [31:0]       mul_multiplicand,
  output logic [31:0]       mul_multiplier,
  output logic              mul_op_start,
  output logic              mul_op_clear,
  input  logic              mul_op_done,
  input  logic [63:0]       mul_result
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned RES_W  = 64;

  localparam logic [ADDR_W-1:0] ADDR_MCAND   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_MPLIER  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_START   = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] ADDR_CLEAR   = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] ADDR_STATUS  = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ADDR_INTR_EN = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] ADDR_RES_H   = ADDR_W'(6);
  localparam logic [ADDR_W-1:0] ADDR_RES_L   = ADDR_W'(7);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_BUSY  = 3'd2,
    S_DONE  = 3'd3,
    S_CLEAR = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   mcand_q, mcand_d;
  logic [DATA_W-1:0]   mplier_q, mplier_d;
  logic                intr_en_q, intr_en_d;
  logic [RES_W-1:0]    result_q, result_d;
  logic                done_q, done_d;
  logic                start_q, start_d;
  logic                clear_q, clear_d;
  logic                irq_q, irq_d;

  logic                wr_en;
  logic                wr_start;
  logic                wr_clear;
  logic                busy;
  logic                operands_frozen;

  assign wr_en           = s_sel & s_wr;
  assign wr_start        = wr_en && (s_addr == ADDR_START) && s_din[0];
  assign wr_clear        = wr_en && (s_addr == ADDR_CLEAR) && s_din[0];
  assign busy            = (state_q == S_START) || (state_q == S_BUSY);
  assign operands_frozen = busy;

  // Next-state, register-update and pulse decode for the command sequencer
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    intr_en_d = intr_en_q;
    result_d  = result_q;
    done_d    = done_q;

    case (state_q)
      S_IDLE:  if (wr_start) state_d = S_START;
      S_START: state_d = S_BUSY;
      S_BUSY: begin
        if (mul_op_done) begin
          result_d = mul_result;
          done_d   = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_DONE;
      S_CLEAR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Clear wins over everything, including a completing operation
    if (wr_clear) begin
      state_d  = S_CLEAR;
      result_d = '0;
      done_d   = 1'b0;
    end

    if (wr_en && !operands_frozen) begin
      if (s_addr == ADDR_MCAND)  mcand_d  = s_din;
      if (s_addr == ADDR_MPLIER) mplier_d = s_din;
    end
    if (wr_en && (s_addr == ADDR_INTR_EN)) intr_en_d = s_din[0];

    start_d = (state_d == S_START);
    clear_d = (state_d == S_CLEAR);
    irq_d   = done_d & intr_en_d;
  end

  // State and register bank
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      intr_en_q <= 1'b0;
      result_q  <= '0;
      done_q    <= 1'b0;
      start_q   <= 1'b0;
      clear_q   <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      intr_en_q <= intr_en_d;
      result_q  <= result_d;
      done_q    <= done_d;
      start_q   <= start_d;
      clear_q   <= clear_d;
      irq_q     <= irq_d;
    end
  end

  // Combinational read mux; idle bus and write cycles return zero
  always_comb begin
    s_dout = '0;
    if (s_sel && !s_wr) begin
      case (s_addr)
        ADDR_MCAND:   s_dout = mcand_q;
        ADDR_MPLIER:  s_dout = mplier_q;
        ADDR_STATUS:  s_dout = DATA_W'({busy, done_q});
        ADDR_INTR_EN: s_dout = DATA_W'(intr_en_q);
        ADDR_RES_H:   s_dout = result_q[RES_W-1:DATA_W];
        ADDR_RES_L:   s_dout = result_q[DATA_W-1:0];
        default:      s_dout = '0;
      endcase
    end
  end

  assign mul_multiplicand = mcand_q;
  assign mul_multiplier   = mplier_q;
  assign mul_op_start     = start_q;
  assign mul_op_clear     = clear_q;
  assign m_interrupt      = irq_q;

endmodule

// File: tb/tb_mul_slave_ctrl.sv
// tb_mul_slave_ctrl: self-checking bench for mul_slave_ctrl with a
// behavioural register/operation model and a scripted multiplier stub.
module tb_mul_slave_ctrl;

  localparam int unsigned ADDR_W = 4;

  logic              clk;
  logic              reset_n;
  logic              s_sel;
  logic              s_wr;
  logic [ADDR_W-1:0] s_addr;
  logic [31:0]       s_din;
  logic [31:0]       s_dout;
  logic              m_interrupt;
  logic [31:0]       mul_multiplicand;
  logic [31:0]       mul_multiplier;
  logic              mul_op_start;
  logic              mul_op_clear;
  logic              mul_op_done;
  logic [63:0]       mul_result;

  mul_slave_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .s_sel            (s_sel),
    .s_wr             (s_wr),
    .s_addr           (s_addr),
    .s_din            (s_din),
    .s_dout           (s_dout),
    .m_interrupt      (m_interrupt),
    .mul_multiplicand (mul_multiplicand),
    .mul_multiplier   (mul_multiplier),
    .mul_op_start     (mul_op_start),
    .mul_op_clear     (mul_op_clear),
    .mul_op_done      (mul_op_done),
    .mul_result       (mul_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  // Pulse counters sampled mid-cycle
  int start_cnt = 0;
  int clear_cnt = 0;
  always @(negedge clk) begin
    if (mul_op_start === 1'b1) start_cnt++;
    if (mul_op_clear === 1'b1) clear_cnt++;
  end

  // Behavioural model: operation either running, finished, or neither
  logic [31:0] m_a, m_b;
  logic        m_ien;
  logic        m_running;
  logic        m_done;
  logic [63:0] m_result;

  function automatic void model_reset();
    m_a = '0; m_b = '0; m_ien = 1'b0;
    m_running = 1'b0; m_done = 1'b0; m_result = '0;
  endfunction

  function automatic logic [63:0] prod(logic [31:0] a, logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  function automatic logic [31:0] model_read(int addr);
    case (addr)
      0: return m_a;
      1: return m_b;
      4: return {30'd0, m_running, m_done};
      5: return {31'd0, m_ien};
      6: return m_result[63:32];
      7: return m_result[31:0];
      default: return 32'd0;
    endcase
  endfunction

  function automatic void model_write(int addr, logic [31:0] data);
    if (addr == 3 && data[0]) begin
      m_running = 1'b0; m_done = 1'b0; m_result = '0;
    end else if (addr == 2 && data[0] && !m_running && !m_done) begin
      m_running = 1'b1;
    end
    if (!m_running || (addr == 2)) begin
      if (addr == 0) m_a = data;
      if (addr == 1) m_b = data;
    end
    if (addr == 5) m_ien = data[0];
  endfunction

  task automatic bus_write(int addr, logic [31:0] data);
    @(negedge clk);
    s_sel = 1'b1; s_wr = 1'b1; s_addr = ADDR_W'(addr); s_din = data;
    @(posedge clk);
    #1;
    s_sel = 1'b0; s_wr = 1'b0;
    model_write(addr, data);
  endtask

  task automatic bus_read(int addr, output logic [31:0] data);
    @(negedge clk);
    s_sel = 1'b1; s_wr = 1'b0; s_addr = ADDR_W'(addr);
    #1;
    data = s_dout;
    #1;
    s_sel = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Multiplier stub finishing: done level rises, held until a clear
  task automatic mul_finish(logic [63:0] res);
    @(negedge clk);
    mul_result = res; mul_op_done = 1'b1;
    @(posedge clk);
    #1;
    if (m_running) begin
      m_running = 1'b0; m_done = 1'b1; m_result = res;
    end
  endtask

  task automatic do_clear();
    bus_write(3, 32'd1);
    mul_op_done = 1'b0;
    idle(2);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    reset_n = 1'b0;
    model_reset();
    idle(2);
    total++; if ({mul_op_start, mul_op_clear, m_interrupt} !== 3'b000)
      $display("FAIL reset_pulses: got %b expected 000", {mul_op_start, mul_op_clear, m_interrupt}); else passed++;
    total++; if ({mul_multiplicand, mul_multiplier} !== 64'd0)
      $display("FAIL reset_operands: got %h expected 0", {mul_multiplicand, mul_multiplier}); else passed++;
    @(negedge clk); reset_n = 1'b1;
    for (int a = 0; a < 16; a++) begin
      bus_read(a, rd);
      total++; if (rd !== 32'd0) $display("FAIL reset_read[%0d]: got %h expected 0", a, rd); else passed++;
    end
  endtask

  task automatic test_signed_run();
    logic [31:0] rd;
    int s0;
    bus_write(0, 32'd11);
    bus_write(1, 32'hFFFF_FFF5);
    bus_write(5, 32'd1);
    s0 = start_cnt;
    bus_write(2, 32'd1);
    total++; if (mul_op_start !== 1'b1) $display("FAIL start_latency: got %b expected 1", mul_op_start); else passed++;
    bus_read(4, rd);
    total++; if (rd !== model_read(4)) $display("FAIL status_busy: got %h expected %h", rd, model_read(4)); else passed++;
    idle(3);
    total++; if (start_cnt - s0 !== 1) $display("FAIL start_pulse_count: got %0d expected 1", start_cnt - s0); else passed++;
    total++; if (mul_multiplicand !== m_a || mul_multiplier !== m_b)
      $display("FAIL operand_outputs: got %h/%h expected %h/%h", mul_multiplicand, mul_multiplier, m_a, m_b); else passed++;
    mul_finish(prod(m_a, m_b));
    for (int a = 4; a < 8; a++) begin
      bus_read(a, rd);
      total++; if (rd !== model_read(a)) $display("FAIL signed_read[%0d]: got %h expected %h", a, rd, model_read(a)); else passed++;
    end
    total++; if (m_interrupt !== (m_done & m_ien)) $display("FAIL signed_irq: got %b expected %b", m_interrupt, m_done & m_ien); else passed++;
  endtask

  task automatic test_clear_then_run();
    logic [31:0] rd;
    int c0;
    c0 = clear_cnt;
    bus_write(3, 32'd1);
    total++; if (mul_op_clear !== 1'b1) $display("FAIL clear_latency: got %b expected 1", mul_op_clear); else passed++;
    mul_op_done = 1'b0;
    idle(3);
    total++; if (clear_cnt - c0 !== 1) $display("FAIL clear_pulse_count: got %0d expected 1", clear_cnt - c0); else passed++;
    total++; if (m_interrupt !== 1'b0) $display("FAIL clear_irq: got %b expected 0", m_interrupt); else passed++;
    for (int a = 4; a < 8; a++) begin
      bus_read(a, rd);
      total++; if (rd !== model_read(a)) $display("FAIL clear_read[%0d]: got %h expected %h", a, rd, model_read(a)); else passed++;
    end
    bus_write(0, 32'd6);
    bus_write(1, 32'd6);
    bus_write(2, 32'd1);
    idle(2);
    mul_finish(prod(m_a, m_b));
    for (int a = 6; a < 8; a++) begin
      bus_read(a, rd);
      total++; if (rd !== model_read(a)) $display("FAIL six_read[%0d]: got %h expected %h", a, rd, model_read(a)); else passed++;
    end
  endtask

  task automatic test_busy_freeze();
    logic [31:0] rd;
    int s0;
    do_clear();
    bus_write(2, 32'd1);
    idle(1);
    s0 = start_cnt;
    bus_write(0, 32'd99);
    bus_write(2, 32'd1);
    bus_read(0, rd);
    total++; if (rd !== model_read(0)) $display("FAIL frozen_operand: got %h expected %h", rd, model_read(0)); else passed++;
    bus_read(4, rd);
    total++; if (rd !== model_read(4)) $display("FAIL frozen_status: got %h expected %h", rd, model_read(4)); else passed++;
    idle(2);
    total++; if (start_cnt - s0 !== 0) $display("FAIL extra_start: got %0d expected 0", start_cnt - s0); else passed++;
    mul_finish(prod(m_a, m_b));
    bus_read(7, rd);
    total++; if (rd !== model_read(7)) $display("FAIL frozen_result: got %h expected %h", rd, model_read(7)); else passed++;
  endtask

  task automatic test_clear_abort();
    logic [31:0] rd;
    int c0;
    do_clear();
    bus_write(2, 32'd1);
    idle(2);
    c0 = clear_cnt;
    bus_write(3, 32'd1);
    idle(3);
    total++; if (clear_cnt - c0 !== 1) $display("FAIL abort_clear_count: got %0d expected 1", clear_cnt - c0); else passed++;
    // Stale done while idle must not be captured
    @(negedge clk);
    mul_result = 64'hDEAD_BEEF_1234_5678; mul_op_done = 1'b1;
    idle(4);
    bus_read(4, rd);
    total++; if (rd !== model_read(4)) $display("FAIL stale_status: got %h expected %h", rd, model_read(4)); else passed++;
    bus_read(7, rd);
    total++; if (rd !== model_read(7)) $display("FAIL stale_result: got %h expected %h", rd, model_read(7)); else passed++;
    mul_op_done = 1'b0;
  endtask

  task automatic test_intr_en();
    logic [31:0] rd;
    do_clear();
    bus_write(5, 32'd0);
    bus_write(2, 32'd1);
    idle(2);
    mul_finish(prod(m_a, m_b));
    bus_read(4, rd);
    total++; if (rd !== model_read(4)) $display("FAIL noirq_status: got %h expected %h", rd, model_read(4)); else passed++;
    total++; if (m_interrupt !== 1'b0) $display("FAIL noirq_level: got %b expected 0", m_interrupt); else passed++;
    bus_write(5, 32'd1);
    total++; if (m_interrupt !== (m_done & m_ien)) $display("FAIL irq_enable: got %b expected %b", m_interrupt, m_done & m_ien); else passed++;
    bus_write(5, 32'd0);
    total++; if (m_interrupt !== 1'b0) $display("FAIL irq_disable: got %b expected 0", m_interrupt); else passed++;
  endtask

  task automatic test_unmapped();
    logic [31:0] rd;
    for (int a = 8; a < 16; a++) begin
      bus_write(a, $urandom());
      bus_read(a, rd);
      total++; if (rd !== 32'd0) $display("FAIL unmapped_read[%0d]: got %h expected 0", a, rd); else passed++;
    end
    for (int a = 0; a < 8; a++) begin
      bus_read(a, rd);
      total++; if (rd !== model_read(a)) $display("FAIL map_intact[%0d]: got %h expected %h", a, rd, model_read(a)); else passed++;
    end
    @(negedge clk);
    s_sel = 1'b0; s_wr = 1'b0; s_addr = ADDR_W'(7);
    #1;
    total++; if (s_dout !== 32'd0) $display("FAIL deselected_dout: got %h expected 0", s_dout); else passed++;
  endtask

  task automatic test_random();
    logic [31:0] rd;
    for (int i = 0; i < 12; i++) begin
      do_clear();
      bus_write(0, $urandom());
      bus_write(1, $urandom());
      bus_write(5, 32'($urandom_range(0, 1)));
      bus_write(2, 32'd1);
      idle($urandom_range(1, 6));
      mul_finish(prod(m_a, m_b));
      for (int a = 4; a < 8; a++) begin
        bus_read(a, rd);
        total++; if (rd !== model_read(a)) $display("FAIL rand%0d_read[%0d]: got %h expected %h", i, a, rd, model_read(a)); else passed++;
      end
      total++; if (m_interrupt !== (m_done & m_ien)) $display("FAIL rand%0d_irq: got %b expected %b", i, m_interrupt, m_done & m_ien); else passed++;
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    do_clear();
    bus_write(5, 32'd1);
    bus_write(0, 32'h1234_5678);
    bus_write(2, 32'd1);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    total++; if ({mul_op_start, mul_op_clear, m_interrupt} !== 3'b000)
      $display("FAIL midreset_pulses: got %b expected 000", {mul_op_start, mul_op_clear, m_interrupt}); else passed++;
    total++; if (mul_multiplicand !== 32'd0) $display("FAIL midreset_operand: got %h expected 0", mul_multiplicand); else passed++;
    @(negedge clk); reset_n = 1'b1;
    bus_read(4, rd);
    total++; if (rd !== 32'd0) $display("FAIL midreset_status: got %h expected 0", rd); else passed++;
  endtask

  initial begin
    s_sel = 1'b0; s_wr = 1'b0; s_addr = '0; s_din = '0;
    mul_op_done = 1'b0; mul_result = '0;
    reset_n = 1'b0;
    test_reset();
    test_signed_run();
    test_clear_then_run();
    test_busy_freeze();
    test_clear_abort();
    test_intr_en();
    test_unmapped();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
